counter_scheduler: RTL



---
 rtl/counter_scheduler_pkg.sv | 30 +++
 rtl/counter_scheduler_if.sv | 32 +++
 rtl/counter_scheduler_rr_pick.sv | 39 +++
 rtl/counter_scheduler.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/counter_scheduler_pkg.sv
// counter_sched_pkg
// Shared types and helpers for the counter scheduler:
//   state_t     - scheduler FSM states (IDLE, LOAD, RUN)
//   start_val   - counter start value for a run direction
//   target_val  - counter value at which a run of a given length ends
// Helpers work on 32-bit values; callers truncate to the counter width.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Up runs start from zero, down runs from all-ones.
    function automatic logic [31:0] start_val(input logic dir, input int unsigned width);
        logic [31:0] all_ones;
        all_ones = (32'd1 << width) - 32'd1;
        return dir ? 32'd0 : all_ones;
    endfunction

    // A run of len steps ends at len going up, or at all-ones minus len going down.
    function automatic logic [31:0] target_val(input logic dir, input logic [31:0] len,
                                               input int unsigned width);
        logic [31:0] all_ones;
        all_ones = (32'd1 << width) - 32'd1;
        return dir ? len : (all_ones - len);
    endfunction

endpackage

// File: rtl/counter_scheduler_if.sv
// counter_scheduler_if
// Bundle between the timing clients and the counter scheduler.
//   req, req_len, req_dir, pause : client -> scheduler
//   grant, owner, busy, count,
//   done, abort                  : scheduler -> client
// master = client side, slave = scheduler side.
interface counter_scheduler_if #(
    parameter int NREQ = 4,
    parameter int N    = 4,
    parameter int OW   = $clog2(NREQ)
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_len;
    logic [NREQ-1:0]   req_dir;
    logic              pause;
    logic [NREQ-1:0]   grant;
    logic [OW-1:0]     owner;
    logic              busy;
    logic [N-1:0]      count;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   abort;

    modport master (
        output req, req_len, req_dir, pause,
        input  grant, owner, busy, count, done, abort
    );

    modport slave (
        input  req, req_len, req_dir, pause,
        output grant, owner, busy, count, done, abort
    );
endinterface

// File: rtl/counter_scheduler_rr_pick.sv
// rr_pick
// Combinational round-robin selector. Searches req starting one above
// last, wrapping, and returns the first set index.
//   req    : request vector
//   last   : index granted most recently
//   any    : at least one request is pending
//   winner : selected index (0 when any is low)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int OW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   last,
    output logic            any,
    output logic [OW-1:0]   winner
);

    // cand_idx[k] is the index examined at search distance k+1 from last.
    logic [OW-1:0] cand_idx [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_idx[gi] = OW'((int'(last) + 1 + gi) % NREQ);
        end
    endgenerate

    // Scan from farthest to nearest so the nearest pending request wins.
    always_comb begin
        any    = |req;
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                winner = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler
// Time-shares one N-bit up/down counter between NREQ requesters.
// A round-robin pick in IDLE grants the counter, LOAD latches the owner's
// length/direction and presets the counter, RUN steps it until the target
// is reached (done pulse) or the owner drops its request (abort pulse).
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : client bundle (slave side): req/req_len/req_dir/pause in,
//           grant/owner/busy/count/done/abort out
module counter_scheduler
    import counter_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int N    = 4,
    parameter int OW   = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    counter_scheduler_if.slave  bus
);

    state_t          state_reg, state_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [OW-1:0]   last_reg, last_next;
    logic [N-1:0]    count_reg, count_next;
    logic [N-1:0]    target_reg, target_next;
    logic            dir_reg, dir_next;
    logic [NREQ-1:0] done_reg, done_next;
    logic [NREQ-1:0] abort_reg, abort_next;

    logic            pick_any;
    logic [OW-1:0]   pick_w;
    logic [NREQ-1:0] owner_onehot;
    logic            owner_req;
    logic            sel_dir;
    logic [N-1:0]    sel_len;

    rr_pick #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_pick (
        .req    (bus.req),
        .last   (last_reg),
        .any    (pick_any),
        .winner (pick_w)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign owner_onehot[gi] = (owner_reg == OW'(gi));
        end
    endgenerate

    assign owner_req = bus.req[owner_reg];
    assign sel_dir   = bus.req_dir[owner_reg];
    assign sel_len   = bus.req_len[owner_reg*N +: N];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: abort outranks pause, pause outranks completion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next = LOAD;
                end
            end
            LOAD: state_next = RUN;
            RUN: begin
                if (!owner_req) begin
                    state_next = IDLE;
                end else if (!bus.pause && (count_reg == target_reg)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        owner_next  = owner_reg;
        last_next   = last_reg;
        count_next  = count_reg;
        target_next = target_reg;
        dir_next    = dir_reg;
        done_next   = '0;
        abort_next  = '0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    owner_next = pick_w;
                    last_next  = pick_w;
                end
            end
            LOAD: begin
                // Length and direction are captured here only, so later
                // changes on the request lines do not affect this run.
                dir_next    = sel_dir;
                count_next  = N'(start_val(sel_dir, N));
                target_next = N'(target_val(sel_dir, 32'(sel_len), N));
            end
            RUN: begin
                if (!owner_req) begin
                    abort_next = owner_onehot;
                end else if (!bus.pause) begin
                    if (count_reg == target_reg) begin
                        done_next = owner_onehot;
                    end else if (dir_reg) begin
                        count_next = count_reg + N'(1);
                    end else begin
                        count_next = count_reg - N'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers. last resets to NREQ-1 so index 0 is searched first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_reg  <= '0;
            last_reg   <= OW'(NREQ - 1);
            count_reg  <= '0;
            target_reg <= '0;
            dir_reg    <= 1'b0;
            done_reg   <= '0;
            abort_reg  <= '0;
        end else begin
            owner_reg  <= owner_next;
            last_reg   <= last_next;
            count_reg  <= count_next;
            target_reg <= target_next;
            dir_reg    <= dir_next;
            done_reg   <= done_next;
            abort_reg  <= abort_next;
        end
    end

    assign bus.busy  = (state_reg != IDLE);
    assign bus.grant = (state_reg != IDLE) ? owner_onehot : '0;
    assign bus.owner = owner_reg;
    assign bus.count = count_reg;
    assign bus.done  = done_reg;
    assign bus.abort = abort_reg;

endmodule
